// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet layer engine: layer modes,
// per-layer parameter sets and the engine FSM state encoding.
package lenet_pkg;

    localparam int MODE_CONV = 0;
    localparam int MODE_FC   = 1;

    localparam int LENET_K = 5;

    localparam int C1_DW   = 8;
    localparam int C1_IN_W = 32;
    localparam int C1_IN_H = 32;

    localparam int C3_DW   = 16;
    localparam int C3_IN_W = 14;
    localparam int C3_IN_H = 14;

    localparam int C5_DW    = 32;
    localparam int C5_IN_W  = 5;
    localparam int C5_IN_H  = 5;
    localparam int C5_N_OUT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lenet_mac.sv
// Signed DWxDW multiplier feeding a registered OW-bit accumulator.
// sum_o is the accumulator plus the current product, before it is registered.
module lenet_mac #(
    parameter int DW = 8,
    localparam int OW = 2 * DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          acc_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [OW-1:0] load_val_i,
    output logic [OW-1:0] sum_o
);

    logic [OW-1:0] a_ext;
    logic [OW-1:0] b_ext;
    logic [OW-1:0] prod;
    logic [OW-1:0] acc_reg;

    // Low OW bits of the product are identical for signed and unsigned
    // multiplication once both operands are sign-extended to OW bits.
    assign a_ext = {{DW{a_i[DW-1]}}, a_i};
    assign b_ext = {{DW{b_i[DW-1]}}, b_i};
    assign prod  = a_ext * b_ext;
    assign sum_o = acc_reg + prod;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg <= '0;
        end else if (load_i) begin
            acc_reg <= load_val_i;
        end else if (acc_i) begin
            acc_reg <= sum_o;
        end
    end

endmodule

// File: rtl/lenet_layer_engine.sv
// Single-MAC sequential LeNet layer: valid KxK convolution (MODE 0) or fully
// connected layer (MODE 1), one product accumulated per clock.
module lenet_layer_engine
    import lenet_pkg::*;
#(
    parameter int MODE  = 0,
    parameter int DW    = 8,
    parameter int IN_W  = 32,
    parameter int IN_H  = 32,
    parameter int K     = 5,
    parameter int N_OUT = 10,
    localparam int OW    = 2 * DW,
    localparam int OUT_W = IN_W - K + 1,
    localparam int OUT_H = IN_H - K + 1,
    localparam int LEN   = IN_W * IN_H,
    localparam int NO    = (MODE != 0) ? N_OUT : OUT_W * OUT_H,
    localparam int TAPS  = (MODE != 0) ? LEN : K * K,
    localparam int WN    = (MODE != 0) ? LEN * N_OUT : K * K,
    localparam int BN    = (MODE != 0) ? N_OUT : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN*DW-1:0] data_i,
    input  logic [WN*DW-1:0]  weight_i,
    input  logic [BN*DW-1:0]  bias_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [NO*OW-1:0]  result_o
);

    // Both modes walk a 2-D output grid and a 2-D tap grid; a fully
    // connected layer is a 1 x N_OUT output grid with a 1 x LEN tap grid.
    localparam int O_ROWS = (MODE != 0) ? 1 : OUT_H;
    localparam int O_COLS = (MODE != 0) ? N_OUT : OUT_W;
    localparam int T_ROWS = (MODE != 0) ? 1 : K;
    localparam int T_COLS = (MODE != 0) ? LEN : K;
    localparam int CW     = $clog2(NO * TAPS + 1) + 1;

    state_t state_reg, state_next;

    logic [CW-1:0] row_reg, col_reg, ti_reg, tj_reg;
    logic last_tj, last_ti, last_tap, last_col, last_row, last_out;
    logic cnt_clr, cnt_step, mac_load, mac_acc, res_wr;

    int elem_idx, wt_idx, bias_idx, m_idx;
    logic [DW-1:0] data_sel, wt_sel, bias_sel;
    logic [OW-1:0] bias_ext, sum;

    assign last_tj  = (tj_reg == CW'(T_COLS - 1));
    assign last_ti  = (ti_reg == CW'(T_ROWS - 1));
    assign last_col = (col_reg == CW'(O_COLS - 1));
    assign last_row = (row_reg == CW'(O_ROWS - 1));
    assign last_tap = last_tj && last_ti;
    assign last_out = last_col && last_row;

    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_step   = 1'b0;
        mac_load   = 1'b0;
        mac_acc    = 1'b0;
        res_wr     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_RUN;
                    cnt_clr    = 1'b1;
                    mac_load   = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_step = 1'b1;
                if (last_tap) begin
                    res_wr   = 1'b1;
                    mac_load = 1'b1;
                    if (last_out) begin
                        state_next = ST_DONE;
                    end
                end else begin
                    mac_acc = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Bias index selects the bias for the output about to start: element 0
    // when launching from idle, the next column when finishing an output.
    always_comb begin
        if (MODE != 0) begin
            elem_idx = int'(tj_reg);
            wt_idx   = int'(col_reg) * LEN + int'(tj_reg);
            bias_idx = (state_reg == ST_RUN && !last_col) ? int'(col_reg) + 1 : 0;
        end else begin
            elem_idx = (int'(row_reg) + int'(ti_reg)) * IN_W + int'(col_reg) + int'(tj_reg);
            wt_idx   = int'(ti_reg) * K + int'(tj_reg);
            bias_idx = 0;
        end
        m_idx = int'(row_reg) * O_COLS + int'(col_reg);
    end

    assign data_sel = data_i[elem_idx*DW +: DW];
    assign wt_sel   = weight_i[wt_idx*DW +: DW];
    assign bias_sel = bias_i[bias_idx*DW +: DW];
    assign bias_ext = {{DW{bias_sel[DW-1]}}, bias_sel};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            ti_reg    <= '0;
            tj_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (cnt_clr) begin
                row_reg <= '0;
                col_reg <= '0;
                ti_reg  <= '0;
                tj_reg  <= '0;
            end else if (cnt_step) begin
                if (!last_tj) begin
                    tj_reg <= tj_reg + CW'(1);
                end else begin
                    tj_reg <= '0;
                    if (!last_ti) begin
                        ti_reg <= ti_reg + CW'(1);
                    end else begin
                        ti_reg <= '0;
                        if (!last_col) begin
                            col_reg <= col_reg + CW'(1);
                        end else begin
                            col_reg <= '0;
                            row_reg <= last_row ? '0 : row_reg + CW'(1);
                        end
                    end
                end
            end
        end
    end

    lenet_mac #(
        .DW (DW)
    ) u_mac (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (mac_load),
        .acc_i      (mac_acc),
        .a_i        (data_sel),
        .b_i        (wt_sel),
        .load_val_i (bias_ext),
        .sum_o      (sum)
    );

    for (genvar gi = 0; gi < NO; gi++) begin : g_res
        logic [OW-1:0] elem_reg;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                elem_reg <= '0;
            end else if (res_wr && m_idx == gi) begin
                elem_reg <= sum;
            end
        end
        assign result_o[gi*OW +: OW] = elem_reg;
    end

    assign busy_o = (state_reg != ST_IDLE);
    assign done_o = (state_reg == ST_DONE);

endmodule

// File: tb/tb_lenet_layer_engine.sv
// Self-checking bench for lenet_layer_engine in its c1, c3 and c5 configurations
// against a loop-based arithmetic model of the layer equations.
module tb_lenet_layer_engine;
    import lenet_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start;
    logic [2:0] busy, done;

    logic [1024*8-1:0] data1;  logic [25*8-1:0]   wt1;  logic [7:0]       bias1; logic [784*16-1:0] res1;
    logic [196*16-1:0] data3;  logic [25*16-1:0]  wt3;  logic [15:0]      bias3; logic [100*32-1:0] res3;
    logic [25*32-1:0]  data5;  logic [250*32-1:0] wt5;  logic [10*32-1:0] bias5; logic [10*64-1:0]  res5;

    lenet_layer_engine #(.MODE(MODE_CONV), .DW(C1_DW), .IN_W(C1_IN_W), .IN_H(C1_IN_H), .K(LENET_K), .N_OUT(10)) u_c1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .data_i(data1), .weight_i(wt1), .bias_i(bias1),
        .busy_o(busy[0]), .done_o(done[0]), .result_o(res1));
    lenet_layer_engine #(.MODE(MODE_CONV), .DW(C3_DW), .IN_W(C3_IN_W), .IN_H(C3_IN_H), .K(LENET_K), .N_OUT(10)) u_c3 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .data_i(data3), .weight_i(wt3), .bias_i(bias3),
        .busy_o(busy[1]), .done_o(done[1]), .result_o(res3));
    lenet_layer_engine #(.MODE(MODE_FC), .DW(C5_DW), .IN_W(C5_IN_W), .IN_H(C5_IN_H), .K(LENET_K), .N_OUT(C5_N_OUT)) u_c5 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .data_i(data5), .weight_i(wt5), .bias_i(bias5),
        .busy_o(busy[2]), .done_o(done[2]), .result_o(res5));

    // index 0 = c1, 1 = c3, 2 = c5
    int dw_c[3]   = '{8, 16, 32};
    int inw_c[3]  = '{32, 14, 5};
    int mode_c[3] = '{0, 0, 1};
    int no_c[3]   = '{784, 100, 10};
    int taps_c[3] = '{25, 25, 25};
    int nw_c[3]   = '{25, 25, 250};
    int nb_c[3]   = '{1, 1, 10};

    longint dm[3][1024];
    longint wm[3][250];
    longint bm[3][10];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string tag, longint unsigned obs, longint unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sext(longint v, int dw);
        return (v <<< (64 - dw)) >>> (64 - dw);
    endfunction

    function automatic longint rnd(int dw);
        longint v;
        v = {$urandom, $urandom};
        return sext(v, dw);
    endfunction

    task automatic set_const(int cfg, longint dv, longint wv, longint bv, longint bstep);
        for (int n = 0; n < inw_c[cfg] * inw_c[cfg]; n++) dm[cfg][n] = dv;
        for (int n = 0; n < nw_c[cfg]; n++) wm[cfg][n] = wv;
        for (int n = 0; n < nb_c[cfg]; n++) bm[cfg][n] = bv + bstep * n;
    endtask

    task automatic set_rand(int cfg);
        for (int n = 0; n < inw_c[cfg] * inw_c[cfg]; n++) dm[cfg][n] = rnd(dw_c[cfg]);
        for (int n = 0; n < nw_c[cfg]; n++) wm[cfg][n] = rnd(dw_c[cfg]);
        for (int n = 0; n < nb_c[cfg]; n++) bm[cfg][n] = rnd(dw_c[cfg]);
    endtask

    task automatic pack(int cfg);
        for (int n = 0; n < inw_c[cfg] * inw_c[cfg]; n++) begin
            longint v = dm[cfg][n];
            case (cfg)
                0: data1[n*8 +: 8] = v[7:0];
                1: data3[n*16 +: 16] = v[15:0];
                default: data5[n*32 +: 32] = v[31:0];
            endcase
        end
        for (int n = 0; n < nw_c[cfg]; n++) begin
            longint v = wm[cfg][n];
            case (cfg)
                0: wt1[n*8 +: 8] = v[7:0];
                1: wt3[n*16 +: 16] = v[15:0];
                default: wt5[n*32 +: 32] = v[31:0];
            endcase
        end
        for (int n = 0; n < nb_c[cfg]; n++) begin
            longint v = bm[cfg][n];
            case (cfg)
                0: bias1 = v[7:0];
                1: bias3 = v[15:0];
                default: bias5[n*32 +: 32] = v[31:0];
            endcase
        end
    endtask

    // Layer equations evaluated directly; longint arithmetic wraps mod 2^64,
    // then the result is reduced to the 2*DW output width.
    function automatic longint unsigned expect_out(int cfg, int m);
        longint acc;
        int w = inw_c[cfg];
        int owb = 2 * dw_c[cfg];
        if (mode_c[cfg] == 1) begin
            acc = bm[cfg][m];
            for (int n = 0; n < w * w; n++) acc += dm[cfg][n] * wm[cfg][m * w * w + n];
        end else begin
            int ocols = w - 4;
            int r = m / ocols;
            int c = m % ocols;
            acc = bm[cfg][0];
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    acc += dm[cfg][(r + i) * w + c + j] * wm[cfg][i * 5 + j];
        end
        if (owb < 64) acc = acc & ((64'sd1 <<< owb) - 1);
        return longint'(acc);
    endfunction

    function automatic longint unsigned get_res(int cfg, int m);
        case (cfg)
            0: return {48'd0, res1[m*16 +: 16]};
            1: return {32'd0, res3[m*32 +: 32]};
            default: return res5[m*64 +: 64];
        endcase
    endfunction

    task automatic run(int cfg, int extra_at, int abort_at);
        int lat = no_c[cfg] * taps_c[cfg] + 1;
        int lim = (abort_at > 0) ? abort_at + 300 : lat + 2;
        int first = 0;
        int cnt = 0;
        pack(cfg);
        @(negedge clk); start[cfg] = 1'b1;
        @(negedge clk); start[cfg] = 1'b0;
        check($sformatf("cfg%0d busy_after_start", cfg), busy[cfg], 1);
        for (int n = 1; n <= lim; n++) begin
            if (done[cfg]) begin
                cnt++;
                if (first == 0) first = n;
            end
            if (n == lat + 1 && abort_at == 0)
                check($sformatf("cfg%0d busy_after_done", cfg), busy[cfg], 0);
            start[cfg] = (n == extra_at);
            if (n == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort busy", busy[cfg], 0);
                check("abort done", done[cfg], 0);
                check("abort result_ones", $countones(res1), 0);
            end
            @(negedge clk);
        end
        start[cfg] = 1'b0;
        if (abort_at > 0) begin
            check("abort no_done", cnt, 0);
        end else begin
            check($sformatf("cfg%0d done_latency", cfg), first, lat);
            check($sformatf("cfg%0d done_pulses", cfg), cnt, 1);
            for (int m = 0; m < no_c[cfg]; m++)
                check($sformatf("cfg%0d out[%0d]", cfg, m), get_res(cfg, m), expect_out(cfg, m));
        end
        $display("run cfg%0d extra_start=%0d abort=%0d done_at=%0d pulses=%0d", cfg, extra_at, abort_at, first, cnt);
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        data1 = '0; wt1 = '0; bias1 = '0;
        data3 = '0; wt3 = '0; bias3 = '0;
        data5 = '0; wt5 = '0; bias5 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", {61'd0, busy}, 0);
        check("reset done", {61'd0, done}, 0);
        check("reset res1", $countones(res1), 0);
        check("reset res3", $countones(res3), 0);
        check("reset res5", $countones(res5), 0);

        // c1: all ones with a stray start at cycle 10 of the run
        set_const(0, 1, 1, 0, 0);
        run(0, 10, 0);
        // c1: saturating-size values to exercise 16-bit wrap
        set_const(0, 127, 127, 3, 0);
        run(0, 0, 0);
        // c1: reset mid-run, then the same random data run to completion
        set_rand(0);
        run(0, 0, 100);
        run(0, 0, 0);

        // c3: ramp data with a single -1 tap at (0,0)
        for (int n = 0; n < 196; n++) dm[1][n] = n;
        for (int n = 0; n < 25; n++) wm[1][n] = 0;
        wm[1][0] = -1;
        bm[1][0] = 5;
        run(1, 0, 0);
        set_rand(1);
        run(1, 0, 0);

        // c5: constant data/weights with bias k
        set_const(2, 2, 1, 0, 1);
        run(2, 0, 0);
        set_rand(2);
        run(2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
